// File: rtl/dff_dut_if.sv
// rtl/dff_dut_if.sv - data/control/status bundle for the dff_dut register
// The par signal exists only when DFF_DUT_PARITY_EN is defined.
interface dff_dut_if #(
   parameter int WIDTH = 1
) ();
   logic [WIDTH-1:0] d;
   logic             en;
   logic [WIDTH-1:0] mask;
   logic             clr;
   logic             pre;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] q_n;
   logic             chg;
`ifdef DFF_DUT_PARITY_EN
   logic             par;
`endif

   modport master (
      output d, en, mask, clr, pre,
`ifdef DFF_DUT_PARITY_EN
      input  par,
`endif
      input  q, q_n, chg
   );

   modport slave (
      input  d, en, mask, clr, pre,
`ifdef DFF_DUT_PARITY_EN
      output par,
`endif
      output q, q_n, chg
   );
endinterface

// File: rtl/dff_dut.sv
// rtl/dff_dut.sv - masked-load register with sync clear/preset, change flag, optional parity
// Define DFF_DUT_PARITY_EN to add the par output (even parity of q).
module dff_dut #(
   parameter int               WIDTH       = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic     clk,
   input  logic     rst,
   dff_dut_if.slave bus
);
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;
   logic             chg_q;
   logic             chg_d;
   logic             run_q;

   // run_q keeps the first edge after rst rises from capturing, so release is never partial
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_q   <= RESET_VALUE;
         chg_q <= 1'b0;
         run_q <= 1'b0;
      end else begin
         q_q   <= q_d;
         chg_q <= chg_d;
         run_q <= 1'b1;
      end
   end

   always_comb begin
      q_d = q_q;
      if (run_q) begin
         if (bus.clr) begin
            q_d = '0;
         end else if (bus.pre) begin
            q_d = '1;
         end else if (bus.en) begin
            q_d = (q_q & ~bus.mask) | (bus.d & bus.mask);
         end
      end
      chg_d = (q_d != q_q);
   end

   assign bus.q   = q_q;
   assign bus.q_n = ~q_q;
   assign bus.chg = chg_q;
`ifdef DFF_DUT_PARITY_EN
   assign bus.par = ^q_q;
`endif
endmodule

// File: tb/tb_dff_dut.sv
// tb/tb_dff_dut.sv - vector table plus scoreboard checks for dff_dut (WIDTH=8)
// Parity checks are included when DFF_DUT_PARITY_EN is defined.
module tb_dff_dut;
   typedef struct {
      logic       clr;
      logic       pre;
      logic       en;
      logic [7:0] mask;
      logic [7:0] d;
      logic [7:0] exp_q;
      logic       exp_chg;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;
   vec_t sb_q[$];
   vec_t vecs[16];

   dff_dut_if #(.WIDTH(8)) bus ();

   dff_dut #(.WIDTH(8), .RESET_VALUE(8'h00)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic clr, input logic pre, input logic en,
                               input logic [7:0] mask, input logic [7:0] d,
                               input logic [7:0] exp_q, input logic exp_chg);
      vec_t v;
      v.clr = clr; v.pre = pre; v.en = en; v.mask = mask; v.d = d;
      v.exp_q = exp_q; v.exp_chg = exp_chg;
      return v;
   endfunction

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic check_outputs(input string name, input logic [7:0] exp_q, input logic exp_chg);
      check({name, ".q"}, bus.q, exp_q);
      check({name, ".q_n"}, bus.q_n, ~exp_q);
      check({name, ".chg"}, {7'd0, bus.chg}, {7'd0, exp_chg});
`ifdef DFF_DUT_PARITY_EN
      check({name, ".par"}, {7'd0, bus.par}, {7'd0, ^exp_q});
`endif
   endtask

   task automatic drive(input logic clr, input logic pre, input logic en,
                        input logic [7:0] mask, input logic [7:0] d);
      bus.clr = clr; bus.pre = pre; bus.en = en; bus.mask = mask; bus.d = d;
   endtask

   // Glitch the controls between edges before settling on the real values.
   task automatic step(input int idx, input vec_t v);
      vec_t e;
      @(negedge clk);
      drive(1'b1, 1'b1, ~v.en, ~v.mask, ~v.d);
      #2;
      drive(v.clr, v.pre, v.en, v.mask, v.d);
      sb_q.push_back(v);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check_outputs($sformatf("vec%0d", idx), e.exp_q, e.exp_chg);
   endtask

   initial begin
      vecs[0]  = mk(0, 0, 1, 8'hFF, 8'hA5, 8'hA5, 0);
      vecs[1]  = mk(0, 0, 1, 8'h0F, 8'h3C, 8'hAC, 1);
      vecs[2]  = mk(1, 1, 1, 8'hFF, 8'hFF, 8'h00, 1);
      vecs[3]  = mk(0, 1, 0, 8'h00, 8'h00, 8'hFF, 1);
      vecs[4]  = mk(0, 0, 0, 8'hFF, 8'h00, 8'hFF, 0);
      vecs[5]  = mk(0, 0, 0, 8'hFF, 8'hFF, 8'hFF, 0);
      vecs[6]  = mk(0, 0, 0, 8'hFF, 8'h00, 8'hFF, 0);
      vecs[7]  = mk(0, 0, 0, 8'hFF, 8'hFF, 8'hFF, 0);
      vecs[8]  = mk(0, 0, 1, 8'h00, 8'h00, 8'hFF, 0);
      vecs[9]  = mk(0, 0, 1, 8'hFF, 8'h07, 8'h07, 1);
      vecs[10] = mk(0, 0, 1, 8'hFF, 8'h03, 8'h03, 1);
      vecs[11] = mk(0, 1, 1, 8'hFF, 8'h00, 8'hFF, 1);
      vecs[12] = mk(1, 0, 1, 8'hFF, 8'hFF, 8'h00, 1);
      vecs[13] = mk(1, 0, 0, 8'h00, 8'h00, 8'h00, 0);
      vecs[14] = mk(0, 0, 1, 8'hF0, 8'h5A, 8'h50, 1);
      vecs[15] = mk(0, 0, 1, 8'h0F, 8'h5A, 8'h5A, 1);

      drive(1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF);
      #3;
      check_outputs("reset_initial", 8'h00, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check_outputs("reset_held", 8'h00, 1'b0);

      @(negedge clk);
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b1, 8'hFF, 8'hA5);
      @(posedge clk);
      #1;
      check_outputs("release_edge1", 8'h00, 1'b0);
      @(posedge clk);
      #1;
      check_outputs("release_edge2", 8'hA5, 1'b1);

      for (int i = 0; i < 16; i++) begin
         step(i, vecs[i]);
      end

      @(negedge clk);
      drive(1'b0, 1'b0, 1'b1, 8'hFF, 8'h33);
      #2;
      rst = 1'b0;
      #1;
      check_outputs("midcycle_reset", 8'h00, 1'b0);
      @(posedge clk);
      #1;
      check_outputs("reset_over_load", 8'h00, 1'b0);

      @(negedge clk);
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b1, 8'hFF, 8'hC3);
      @(posedge clk);
      #1;
      check_outputs("rerelease_edge1", 8'h00, 1'b0);
      @(posedge clk);
      #1;
      check_outputs("rerelease_edge2", 8'hC3, 1'b1);
      @(posedge clk);
      #1;
      check_outputs("reload_same", 8'hC3, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/dff_dut.md
DFF_DUT -- requirements
Module: dff_dut

Interface
REQ-001 Parameter WIDTH, default 1, data width in bits (legal range 1..64).
REQ-002 Parameter RESET_VALUE, default all-zero, WIDTH-bit value loaded into q on reset.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: clock port clk, reset port rst.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 d  input  WIDTH  data to capture.
REQ-007 en  input  1  load enable; high = capture masked d bits.
REQ-008 mask  input  WIDTH  per-bit write mask; 1 = bit updated when en high.
REQ-009 clr  input  1  synchronous clear to all-zero.
REQ-010 pre  input  1  synchronous preset to all-ones.
REQ-011 q  output  WIDTH  registered data.
REQ-012 q_n  output  WIDTH  bitwise complement of q, combinational from q.
REQ-013 chg  output  1  registered flag, high for one cycle when q changed at the last edge.
REQ-014 par  output  1  even parity (XOR reduction) of q; present only with DFF_DUT_PARITY_EN.

Function
REQ-015 Update priority on each rising clk edge SHALL be: clr, then pre, then en, then hold.
REQ-016 clr=1 SHALL set q to all-zero regardless of pre, en, mask and d.
REQ-017 pre=1 with clr=0 SHALL set q to all-ones regardless of en, mask and d.
REQ-018 en=1 with clr=0 and pre=0 SHALL set q[i]=d[i] where mask[i]=1 and hold q[i] where mask[i]=0.
REQ-019 en=0 with clr=0 and pre=0 SHALL hold q unchanged.
REQ-020 Capture latency SHALL be one edge: d sampled at edge N appears on q immediately after edge N.
REQ-021 chg SHALL be registered as (next q != current q) at each edge: high for exactly the cycle after a value change, low otherwise.
REQ-022 Repeated loads of an identical value SHALL leave chg low.
REQ-023 q_n SHALL equal ~q at all times, including during reset.
REQ-024 With en=1 and mask all-zero, q SHALL hold and chg SHALL stay low.
REQ-025 Inputs SHALL be sampled only at rising clk edges; glitches between edges SHALL have no effect.

Reset
REQ-026 rst=0 SHALL immediately, without waiting for a clk edge, force q=RESET_VALUE, q_n=~RESET_VALUE and chg=0.
REQ-027 While rst=0, all of d, en, mask, clr and pre SHALL be ignored.
REQ-028 Reset release SHALL be synchronised internally, so the first capture occurs at the second rising clk edge after rst rises.
REQ-029 Reset asserted mid-operation SHALL override any in-flight load; no partial update SHALL be visible.

Configuration
REQ-030 Macro DFF_DUT_PARITY_EN defined: port par SHALL exist and equal ^q combinationally, so par=^RESET_VALUE during reset.
REQ-031 Macro DFF_DUT_PARITY_EN undefined: port par and all parity logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-032 WIDTH=8, RESET_VALUE=8'h00: rst=0 mid-cycle -> q=8'h00, q_n=8'hFF, chg=0 immediately, before the next edge.
REQ-033 After reset release, en=1, mask=8'hFF, d=8'hA5 -> q=8'hA5 one edge later with chg=1; same d again on the next edge -> chg=0.
REQ-034 q=8'hA5, en=1, mask=8'h0F, d=8'h3C -> q=8'hAC.
REQ-035 clr=1 and pre=1 together, en=1, d=8'hFF -> q=8'h00; then clr=0, pre=1 -> q=8'hFF with chg=1.
REQ-036 en=0, d toggling 8'h00/8'hFF for 4 edges -> q holds its value and chg stays 0.
REQ-037 With DFF_DUT_PARITY_EN defined, load 8'h07 -> par=1; load 8'h03 -> par=0; with the macro undefined the design elaborates without a par port.
